// File: rtl/sample_pkg.sv
// Shared types and defaults for the sample capture stage.
package sample_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_VALID = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sample_capture_stage.sv
// Two-phase request consumer: captures bundled data and hands it downstream on valid/ready.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no word held; capture when a request is pending and holds low
// ST_VALID | word held on out_data; waiting for out_ready to ack upstream
module sample_capture_stage
    import sample_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re_req,
    output logic             re_ack,
    input  logic             hold_a,
    input  logic             hold_b,
    input  logic [WIDTH-1:0] data_in,
    output logic             sample,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_count,
    output logic             err
);

    logic             req_s;
    logic             pending;

    state_t           state_q, state_d;
    logic             re_ack_q, re_ack_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             req_s_prev_q, req_s_prev_d;
    logic             valid_prev_q, valid_prev_d;

    sync2 u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (re_req),
        .q   (req_s)
    );

    assign pending = req_s ^ re_ack_q;
    assign sample  = (state_q == ST_IDLE) & pending & ~hold_a & ~hold_b;

    always_comb begin
        state_d     = state_q;
        re_ack_d    = re_ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sample) begin
                    out_data_d  = data_in;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_valid_q && out_ready) begin
                    re_ack_d    = ~re_ack_q;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // A req_s edge that landed while the previous cycle was VALID means upstream
    // toggled again before seeing our ack; flagged one cycle after it is observed.
    always_comb begin
        req_s_prev_d = req_s;
        valid_prev_d = (state_q == ST_VALID);
        err_d        = err_q | ((req_s != req_s_prev_q) & valid_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            re_ack_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            req_s_prev_q <= 1'b0;
            valid_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            re_ack_q     <= re_ack_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            req_s_prev_q <= req_s_prev_d;
            valid_prev_q <= valid_prev_d;
        end
    end

    assign re_ack       = re_ack_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign sample_count = cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sample_capture_stage.sv
// Self-checking bench for sample_capture_stage using a transaction-level model of the handshake.
module tb_sample_capture_stage;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          re_req = 1'b0;
    logic          hold_a = 1'b0;
    logic          hold_b = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          re_ack;
    logic          sample;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [CW-1:0] sample_count;
    logic          err;

    sample_capture_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .re_req       (re_req),
        .re_ack       (re_ack),
        .hold_a       (hold_a),
        .hold_b       (hold_b),
        .data_in      (data_in),
        .sample       (sample),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sample_count (sample_count),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // upstream request level, expected ack level, capture count, sticky error
    bit m_req = 1'b0;
    bit m_ack = 1'b0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        repeat (cyc) step();
        m_ack = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", sample_count, 0);
        chk("rst_ack", re_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_sample", sample, 0);
        rst = 1'b0;
    endtask

    // One full request/capture/handshake; ha/hb = stall cycles on hold_a then hold_b,
    // rdy_dly = cycles of backpressure, dbl = upstream toggles twice while VALID.
    task automatic run_txn(input logic [W-1:0] d, input int ha, input int hb,
                           input int rdy_dly, input bit dbl);
        data_in = d;
        m_req   = ~m_req;
        re_req  = m_req;
        hold_a  = (ha > 0);
        hold_b  = (ha == 0) && (hb > 0);
        step();
        chk("smp_edge_k", sample, 0);
        step();
        for (int i = 0; i < ha + hb; i++) begin
            hold_a = (i < ha);
            hold_b = (i >= ha);
            #1;
            chk("stall_sample", sample, 0);
            chk("stall_valid", out_valid, 0);
            step();
        end
        hold_a = 1'b0;
        hold_b = 1'b0;
        #1;
        chk("pre_cap_sample", sample, 1);
        chk("pre_cap_valid", out_valid, 0);
        step();
        m_cnt = (m_cnt + 1) % (1 << CW);
        chk("cap_valid", out_valid, 1);
        chk("cap_data", out_data, d);
        chk("cap_cnt", sample_count, m_cnt);
        chk("cap_ack", re_ack, m_ack);
        chk("cap_sample", sample, 0);
        for (int i = 0; i < rdy_dly; i++) begin
            data_in = W'($urandom);
            hold_a  = 1'($urandom);
            hold_b  = 1'($urandom);
            if (dbl && (i == 0 || i == 3)) begin
                m_req  = ~m_req;
                re_req = m_req;
                m_err  = 1'b1;
            end
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, d);
            chk("bp_ack", re_ack, m_ack);
        end
        hold_a    = 1'b0;
        hold_b    = 1'b0;
        out_ready = 1'b1;
        step();
        m_ack = ~m_ack;
        out_ready = 1'b0;
        chk("hs_ack", re_ack, m_ack);
        chk("hs_valid", out_valid, 0);
        chk("hs_sample", sample, 0);
        chk("hs_err", err, m_err);
    endtask

    initial begin
        do_reset(2);
        repeat (5) begin
            step();
            chk("idle_sample", sample, 0);
            chk("idle_valid", out_valid, 0);
        end

        run_txn(8'hA5, 0, 0, 0, 1'b0);
        run_txn(8'h5A, 4, 2, 1, 1'b0);
        run_txn(8'h3C, 0, 0, 6, 1'b0);
        run_txn(W'($urandom), 0, 0, 10, 1'b1);
        step();
        chk("err_sticky", err, 1);
        do_reset(1);

        for (int t = 0; t < 17; t++)
            run_txn(W'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 4), 1'b0);
        chk("wrap_cnt", sample_count, 1);
        chk("wrap_ack", re_ack, 1);

        // get upstream level to 0 so the next toggle leaves re_req high over reset
        if (m_req)
            run_txn(W'($urandom), 0, 0, 0, 1'b0);
        data_in = 8'h77;
        m_req   = ~m_req;
        re_req  = m_req;
        repeat (3) step();
        chk("mid_cap_valid", out_valid, 1);
        chk("mid_cap_data", out_data, 8'h77);
        do_reset(1);
        data_in = 8'h99;
        step();
        chk("post_rst_smp1", sample, 0);
        step();
        chk("post_rst_smp2", sample, 1);
        step();
        m_cnt = 1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h99);
        chk("post_rst_cnt", sample_count, m_cnt);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        m_ack = ~m_ack;
        chk("post_rst_ack", re_ack, m_ack);
        chk("post_rst_done", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
